dummy_adc_pulse_gen: RTL
========================

Name: dummy_adc_pulse_gen

Overview:
- Stimulus source that drives the RFDC-format H-gain stream consumed by the DSP stage, so the DSP stage can be exercised without real converter hardware.
- Emits a periodic rectangular pulse on top of a configurable baseline.
- Each sample is ADC_RESOLUTION_WIDTH bits, left-justified in a SAMPLE_WIDTH lane, with SAMPLE_NUM_PER_CLK lanes per beat.
- Also emits a per-pulse marker so benches can align DSP output with injected pulses.

Parameters:
SAMPLE_WIDTH, 16, bits per lane.
ADC_RESOLUTION_WIDTH, 12, ADC sample bits, signed two's complement.
SAMPLE_NUM_PER_CLK, 8, lanes per beat.
CNT_WIDTH, 16, width of period and pulse-length counters.

Ports:
ACLK  in  1  clock.
ARESET  in  1  synchronous, active-high reset.
ENABLE  in  1  generator run enable.
SET_CONFIG  in  1  one-cycle strobe; latches all config inputs.
BASELINE  in  ADC_RESOLUTION_WIDTH+1  signed baseline level.
HEIGHT  in  ADC_RESOLUTION_WIDTH+1  signed pulse height added to the baseline.
PERIOD  in  CNT_WIDTH  beats per pulse period.
PULSE_LEN  in  CNT_WIDTH  beats of pulse at the start of each period.
M_AXIS_TDATA  out  SAMPLE_WIDTH*SAMPLE_NUM_PER_CLK  packed samples.
M_AXIS_TVALID  out  1  beat valid.
PULSE_START  out  1  high on the first beat of each pulse.

Behaviour:
- Reset and clock: ARESET is synchronous and active-high; the clock is ACLK. All state is updated only on the rising edge of ACLK.
- Reset values:
  - Config registers: baseline=-1024, height=0, period=16, pulse_len=2.
  - Outputs: M_AXIS_TDATA=0, M_AXIS_TVALID=0, PULSE_START=0.
  - Internal: state=IDLE, cnt=0.
- Config load:
  - On SET_CONFIG (when ARESET is low), the config registers load from the inputs.
  - Effective period = max(PERIOD,2).
  - SET_CONFIG forces state=IDLE and cnt=0. Outputs in the next cycle: TVALID=0, TDATA=0, PULSE_START=0.
  - If ARESET and SET_CONFIG are high together, ARESET wins.
- States:
  - IDLE: TVALID=0, TDATA=0. Leaves to RUN when ENABLE=1 and SET_CONFIG=0, with cnt=0.
  - RUN: TVALID=1 every beat.
  - Counter: cnt counts 0..period-1 and wraps to 0.
  - Leaving RUN: ENABLE=0 returns to IDLE at the next edge; TVALID=0 from that edge onward and cnt is cleared.
- Pulse window:
  - Pulse is active when cnt < pulse_len.
  - pulse_len=0: no pulse ever.
  - pulse_len >= period: pulse is active every beat.
- Sample value:
  - s = baseline + (pulse ? height : 0), computed at ADC_RESOLUTION_WIDTH+2 bits.
  - Saturate to the range [-2^(ADC_RESOLUTION_WIDTH-1), 2^(ADC_RESOLUTION_WIDTH-1)-1], i.e. [-2048, 2047].
  - The same value is placed on all lanes.
- Packing:
  - Lane i bits [i*SAMPLE_WIDTH + (SAMPLE_WIDTH-ADC_RESOLUTION_WIDTH) +: ADC_RESOLUTION_WIDTH] = s.
  - The low SAMPLE_WIDTH-ADC_RESOLUTION_WIDTH bits of each lane are 0.
- PULSE_START: 1 on the beat where cnt==0 and pulse_len!=0 in RUN; otherwise 0.
- Latency:
  - Outputs are registered.
  - With ENABLE rising at edge k (and SET_CONFIG=0), the first valid beat (cnt=0) appears after edge k+1.
  - TDATA, TVALID and PULSE_START are mutually aligned.
- Backpressure: none (matches the RFDC stream). The consumer must accept every valid beat.

Optional Feature:
- Macro: DUMMY_ADC_NOISE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset and on SET_CONFIG) advances once per RUN beat.
  - Lane i adds a signed 2-bit noise value taken from LFSR bits [2i+1:2i] (i taken mod 8), range -2..+1.
  - Noise is added before saturation.
- Undefined: no noise; all lanes are identical.

Test Plan:
- Reset, then ENABLE=1 with default config -> first valid beat 2 edges after ENABLE. Every lane field is 12'hC00 (-1024) with low nibble 0; lanes read 16'hC000. PULSE_START=1 at cnt=0 and every 16 beats; beats 0-1 still carry -1024 because height=0.
- SET_CONFIG with BASELINE=100, HEIGHT=500, PERIOD=10, PULSE_LEN=3, then ENABLE -> beats 0-2 lanes=600 (16'h2580), beats 3-9 lanes=100 (16'h0640), repeating every 10 beats.
- BASELINE=2000, HEIGHT=1000 -> pulse lanes saturate to 2047 (16'h7FF0). BASELINE=-2000, HEIGHT=-1000 -> pulse lanes saturate to -2048 (16'h8000).
- PULSE_LEN=0 -> PULSE_START never asserts and all beats carry the baseline. PULSE_LEN=20 with PERIOD=10 -> all beats carry the pulse value and PULSE_START asserts every 10 beats. PERIOD=0 behaves as period 2.
- SET_CONFIG mid-pulse while ENABLE=1 -> TVALID=0 for the cycle after the strobe, then restart at cnt=0 with the new values. ARESET mid-run -> all outputs 0 and config back to defaults.
- ENABLE dropped mid-period -> TVALID falls after the next edge. On re-enable, the sequence restarts at cnt=0 with PULSE_START=1.

Source files
------------

// File: rtl/dummy_adc_pulse_gen_if.sv
// Sample-stream bundle driven by dummy_adc_pulse_gen: packed lanes, beat valid
// and the per-pulse alignment marker. There is no ready; the consumer takes every beat.
interface dummy_adc_pulse_gen_if #(
  parameter int SAMPLE_WIDTH       = 16,
  parameter int SAMPLE_NUM_PER_CLK = 8
);
  logic [SAMPLE_WIDTH*SAMPLE_NUM_PER_CLK-1:0] tdata;
  logic                                       tvalid;
  logic                                       pulse_start;

  modport master (output tdata, tvalid, pulse_start);
  modport slave  (input  tdata, tvalid, pulse_start);
endinterface

// File: rtl/dummy_adc_pulse_gen.sv
// Dummy ADC source: a periodic rectangular pulse on a baseline, packed as RFDC-style
// left-justified lanes. Define DUMMY_ADC_NOISE_EN to add per-lane LFSR noise.
module dummy_adc_pulse_gen #(
  parameter int SAMPLE_WIDTH         = 16,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int SAMPLE_NUM_PER_CLK   = 8,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic                                   ENABLE,
  input  logic                                   SET_CONFIG,
  input  logic signed [ADC_RESOLUTION_WIDTH:0]   BASELINE,
  input  logic signed [ADC_RESOLUTION_WIDTH:0]   HEIGHT,
  input  logic        [CNT_WIDTH-1:0]            PERIOD,
  input  logic        [CNT_WIDTH-1:0]            PULSE_LEN,
  dummy_adc_pulse_gen_if.master                  m_axis
);

  localparam int DATA_W = SAMPLE_WIDTH * SAMPLE_NUM_PER_CLK;
  localparam int PAD_W  = SAMPLE_WIDTH - ADC_RESOLUTION_WIDTH;
  // One bit beyond baseline+height headroom so the noise term can never wrap the sum.
  localparam int SUM_W  = ADC_RESOLUTION_WIDTH + 3;

  typedef logic signed [ADC_RESOLUTION_WIDTH:0]   level_t;
  typedef logic signed [ADC_RESOLUTION_WIDTH-1:0] sample_t;
  typedef logic signed [SUM_W-1:0]                sum_t;
  typedef logic        [CNT_WIDTH-1:0]            cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam level_t DEF_BASELINE  = level_t'(-1024);
  localparam level_t DEF_HEIGHT    = level_t'(0);
  localparam cnt_t   DEF_PERIOD    = cnt_t'(16);
  localparam cnt_t   DEF_PULSE_LEN = cnt_t'(2);
  localparam cnt_t   MIN_PERIOD    = cnt_t'(2);
  localparam sum_t   SAT_MAX       = sum_t'((1 << (ADC_RESOLUTION_WIDTH-1)) - 1);
  localparam sum_t   SAT_MIN       = sum_t'(-(1 << (ADC_RESOLUTION_WIDTH-1)));

  function automatic sum_t widen(input level_t v);
    return sum_t'(v);
  endfunction

  function automatic sample_t saturate(input sum_t v);
    if (v > SAT_MAX)      return sample_t'(SAT_MAX);
    else if (v < SAT_MIN) return sample_t'(SAT_MIN);
    else                  return sample_t'(v);
  endfunction

  // Configuration registers
  level_t baseline_q;
  level_t height_q;
  cnt_t   period_q;
  cnt_t   pulse_len_q;

  // Sequencer state
  state_t state_q, state_d;
  cnt_t   cnt_q,   cnt_d;

  // Registered stream outputs
  logic [DATA_W-1:0] tdata_q,       tdata_d;
  logic              tvalid_q,      tvalid_d;
  logic              pulse_start_q, pulse_start_d;

  // Datapath
  logic              pulse_active;
  sum_t              base_sum;
  sum_t              lane_sum;
  logic [DATA_W-1:0] beat_data;

`ifdef DUMMY_ADC_NOISE_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] lfsr_next;

  function automatic sum_t lane_noise(input logic [15:0] lfsr, input int lane);
    logic [1:0] bits;
    bits = lfsr[2*(lane % 8) +: 2];
    return sum_t'(signed'(bits));
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif

  // Sample for the current cnt, replicated (plus optional noise) across all lanes.
  always_comb begin
    pulse_active = (cnt_q < pulse_len_q);
    base_sum     = widen(baseline_q) + (pulse_active ? widen(height_q) : sum_t'(0));
    beat_data    = '0;
    lane_sum     = '0;
    for (int i = 0; i < SAMPLE_NUM_PER_CLK; i++) begin
`ifdef DUMMY_ADC_NOISE_EN
      lane_sum = base_sum + lane_noise(lfsr_q, i);
`else
      lane_sum = base_sum;
`endif
      beat_data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = {saturate(lane_sum), {PAD_W{1'b0}}};
    end
  end

  // Next-state and next-output logic.
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tvalid_d      = 1'b0;
    tdata_d       = '0;
    pulse_start_d = 1'b0;
`ifdef DUMMY_ADC_NOISE_EN
    lfsr_d        = lfsr_q;
`endif

    if (SET_CONFIG) begin
      state_d = IDLE;
      cnt_d   = '0;
`ifdef DUMMY_ADC_NOISE_EN
      lfsr_d  = LFSR_SEED;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ENABLE) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          if (!ENABLE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            tvalid_d      = 1'b1;
            tdata_d       = beat_data;
            pulse_start_d = (cnt_q == '0) && (pulse_len_q != '0);
            cnt_d         = (cnt_q >= period_q - cnt_t'(1)) ? '0 : cnt_q + cnt_t'(1);
`ifdef DUMMY_ADC_NOISE_EN
            lfsr_d        = lfsr_next;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      pulse_start_q <= 1'b0;
      baseline_q    <= DEF_BASELINE;
      height_q      <= DEF_HEIGHT;
      period_q      <= DEF_PERIOD;
      pulse_len_q   <= DEF_PULSE_LEN;
`ifdef DUMMY_ADC_NOISE_EN
      lfsr_q        <= LFSR_SEED;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      pulse_start_q <= pulse_start_d;
`ifdef DUMMY_ADC_NOISE_EN
      lfsr_q        <= lfsr_d;
`endif
      if (SET_CONFIG) begin
        baseline_q  <= BASELINE;
        height_q    <= HEIGHT;
        period_q    <= (PERIOD < MIN_PERIOD) ? MIN_PERIOD : PERIOD;
        pulse_len_q <= PULSE_LEN;
      end
    end
  end

  assign m_axis.tdata       = tdata_q;
  assign m_axis.tvalid      = tvalid_q;
  assign m_axis.pulse_start = pulse_start_q;

endmodule
